// File: rtl/axi4_str_src_if.sv
// AXI4-Stream bundle between a stream source (master) and its sink (slave).
interface axi4_str_src_if #(
  parameter int DATA_WDTH = 8
);
  logic [DATA_WDTH-1:0] tdata;
  logic                 tvalid;
  logic                 tlast;
  logic                 tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axi4_str_src.sv
// AXI4-Stream traffic source: pkt_num packets of pkt_len beats from a seed.
// Define AXIS_SRC_LFSR_EN to replace the incrementing pattern with a Galois LFSR.
module axi4_str_src #(
  parameter int DATA_WDTH = 8,
  parameter int LEN_WDTH  = 8,
  parameter int NUM_WDTH  = 8,
  parameter int GAP_CYC   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WDTH-1:0]  pkt_len,
  input  logic [NUM_WDTH-1:0]  pkt_num,
  input  logic [DATA_WDTH-1:0] seed,
  axi4_str_src_if.master       m_axis,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          tx_beats
);

  generate
    if (DATA_WDTH != 8 && DATA_WDTH != 16 && DATA_WDTH != 32 && DATA_WDTH != 64) begin : g_bad_width
      $fatal(1, "axi4_str_src: DATA_WDTH must be 8, 16, 32 or 64");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;
  localparam int GAP_W = $clog2(GAP_CYC + 2);

`ifdef AXIS_SRC_LFSR_EN
  localparam logic [63:0] TAPS_ALL = (DATA_WDTH == 8)  ? 64'h00000000000000B8 :
                                     (DATA_WDTH == 16) ? 64'h000000000000B400 :
                                     (DATA_WDTH == 32) ? 64'h0000000080200003 :
                                                         64'hD800000000000000;
  localparam logic [DATA_WDTH-1:0] TAPS = TAPS_ALL[DATA_WDTH-1:0];
`endif

  function automatic logic [DATA_WDTH-1:0] next_pat(input logic [DATA_WDTH-1:0] d);
`ifdef AXIS_SRC_LFSR_EN
    return (d >> 1) ^ (d[0] ? TAPS : '0);
`else
    return d + DATA_WDTH'(1);
`endif
  endfunction

  // The LFSR would lock up in the all-zero state, so a zero seed becomes all-ones.
  function automatic logic [DATA_WDTH-1:0] seed_fix(input logic [DATA_WDTH-1:0] s);
`ifdef AXIS_SRC_LFSR_EN
    return (s == '0) ? '1 : s;
`else
    return s;
`endif
  endfunction

  state_t               state_reg, state_next;
  logic [LEN_WDTH-1:0]  len_m1_reg, len_m1_next;
  logic [NUM_WDTH-1:0]  num_m1_reg, num_m1_next;
  logic [LEN_WDTH-1:0]  beat_reg, beat_next;
  logic [NUM_WDTH-1:0]  pkt_reg, pkt_next;
  logic [GAP_W-1:0]     gap_reg, gap_next;
  logic [DATA_WDTH-1:0] data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 last_reg, last_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic [31:0]          beats_reg, beats_next;

  logic accept, hs, pkt_end, run_end, gap_end;

  assign accept  = start && (pkt_len != '0) && (pkt_num != '0);
  assign hs      = valid_reg && m_axis.tready;
  assign pkt_end = hs && last_reg;
  assign run_end = pkt_end && (pkt_reg == num_m1_reg);
  assign gap_end = (gap_reg == GAP_W'(GAP_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      len_m1_reg <= '0;
      num_m1_reg <= '0;
      beat_reg   <= '0;
      pkt_reg    <= '0;
      gap_reg    <= '0;
      data_reg   <= '0;
      valid_reg  <= 1'b0;
      last_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      beats_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      len_m1_reg <= len_m1_next;
      num_m1_reg <= num_m1_next;
      beat_reg   <= beat_next;
      pkt_reg    <= pkt_next;
      gap_reg    <= gap_next;
      data_reg   <= data_next;
      valid_reg  <= valid_next;
      last_reg   <= last_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      beats_reg  <= beats_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SEND;
      SEND: begin
        if (run_end)                     state_next = FIN;
        else if (pkt_end && GAP_CYC > 0) state_next = GAP;
      end
      GAP:     if (gap_end) state_next = SEND;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    len_m1_next = len_m1_reg;
    num_m1_next = num_m1_reg;
    beat_next   = beat_reg;
    pkt_next    = pkt_reg;
    gap_next    = gap_reg;
    data_next   = data_reg;
    valid_next  = valid_reg;
    last_next   = last_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    beats_next  = beats_reg + 32'(hs);
    case (state_reg)
      IDLE: begin
        if (accept) begin
          len_m1_next = pkt_len - LEN_WDTH'(1);
          num_m1_next = pkt_num - NUM_WDTH'(1);
          data_next   = seed_fix(seed);
          beat_next   = '0;
          pkt_next    = '0;
          valid_next  = 1'b1;
          last_next   = (pkt_len == LEN_WDTH'(1));
          busy_next   = 1'b1;
        end
      end
      SEND: begin
        if (hs) begin
          data_next = next_pat(data_reg);
          if (run_end) begin
            valid_next = 1'b0;
            last_next  = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else if (pkt_end) begin
            pkt_next  = pkt_reg + NUM_WDTH'(1);
            beat_next = '0;
            gap_next  = '0;
            if (GAP_CYC > 0) begin
              valid_next = 1'b0;
              last_next  = 1'b0;
            end else begin
              last_next = (len_m1_reg == '0);
            end
          end else begin
            beat_next = beat_reg + LEN_WDTH'(1);
            last_next = ((beat_reg + LEN_WDTH'(1)) == len_m1_reg);
          end
        end
      end
      GAP: begin
        if (gap_end) begin
          valid_next = 1'b1;
          last_next  = (len_m1_reg == '0);
        end else begin
          gap_next = gap_reg + GAP_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign m_axis.tdata  = data_reg;
  assign m_axis.tvalid = valid_reg;
  assign m_axis.tlast  = last_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign tx_beats      = beats_reg;

endmodule

// File: tb/tb_axi4_str_src.sv
// Bench for axi4_str_src: two instances (GAP_CYC 0 and 3) checked every cycle against a
// closed-form beat model; honours AXIS_SRC_LFSR_EN for the expected data pattern.
module tb_axi4_str_src;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          tready = 1'b0;
  logic [7:0]    pkt_len = '0;
  logic [7:0]    pkt_num = '0;
  logic [DW-1:0] seed = '0;

  logic [DW-1:0] o_data [2];
  logic          o_valid [2];
  logic          o_last [2];
  logic          o_busy [2];
  logic          o_done [2];
  logic [31:0]   o_beats [2];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      axi4_str_src_if #(.DATA_WDTH(DW)) axis ();
      assign axis.tready = tready;
      axi4_str_src #(
        .DATA_WDTH(DW), .LEN_WDTH(8), .NUM_WDTH(8), .GAP_CYC(gi * 3)
      ) dut (
        .clk(clk), .rst(rst), .start(start), .pkt_len(pkt_len), .pkt_num(pkt_num),
        .seed(seed), .m_axis(axis), .busy(o_busy[gi]), .done(o_done[gi]),
        .tx_beats(o_beats[gi])
      );
      assign o_data[gi]  = axis.tdata;
      assign o_valid[gi] = axis.tvalid;
      assign o_last[gi]  = axis.tlast;
    end
  endgenerate

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model: run parameters plus per-instance progress through the run.
  logic [DW-1:0] r_seed = '0;
  int r_len = 1;
  int r_num = 1;
  int hs_idx [2] = '{1, 1};
  int tot [2] = '{0, 0};
  int pkts [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int gap_cnt [2] = '{0, 0};
  bit gap_open [2] = '{0, 0};
  bit stall [2] = '{0, 0};
  logic [DW-1:0] pdata [2];
  logic plast [2];

  logic [DW-1:0] cap_d [16];
  logic cap_l [16];
  int n_cap = 0;
  int first_hs_cyc = 0;
  int last_hs_cyc = 0;
  int done_cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [DW-1:0] s, input int idx);
    logic [DW-1:0] d;
`ifdef AXIS_SRC_LFSR_EN
    d = (s == '0) ? '1 : s;
    for (int k = 0; k < idx; k++) d = d[0] ? ((d >> 1) ^ 8'hB8) : (d >> 1);
`else
    d = s + DW'(idx);
`endif
    return d;
  endfunction

  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      bit hs;
      hs = o_valid[i] && tready;
      chk("tx_beats", o_beats[i], tot[i]);
      if (stall[i]) begin
        chk("stall_valid", o_valid[i], 1);
        chk("stall_data", o_data[i], pdata[i]);
        chk("stall_last", o_last[i], plast[i]);
      end
      if (gap_open[i]) begin
        if (!o_valid[i]) gap_cnt[i]++;
        else begin
          chk("gap_len", gap_cnt[i], i * 3);
          gap_open[i] = 0;
        end
      end
      if (o_valid[i]) begin
        chk("beat_in_run", hs_idx[i] < r_len * r_num, 1);
        chk("busy_while_valid", o_busy[i], 1);
        chk("tdata", o_data[i], pat(r_seed, hs_idx[i]));
        chk("tlast", o_last[i], (hs_idx[i] % r_len) == r_len - 1);
      end
      if (hs) begin
        if (i == 0) begin
          if (n_cap < 16) begin
            cap_d[n_cap] = o_data[i];
            cap_l[n_cap] = o_last[i];
          end
          if (n_cap == 0) first_hs_cyc = cyc;
          n_cap++;
          last_hs_cyc = cyc;
        end
        if ((hs_idx[i] % r_len) == r_len - 1) begin
          pkts[i]++;
          if (pkts[i] < r_num) begin
            gap_open[i] = 1;
            gap_cnt[i] = 0;
          end
        end
        tot[i]++;
        hs_idx[i]++;
      end
      if (o_done[i]) begin
        done_cnt[i]++;
        if (i == 0) done_cyc = cyc;
        chk("done_beats", hs_idx[i], r_len * r_num);
        chk("busy_in_done", o_busy[i], 0);
      end
      stall[i] = o_valid[i] && !tready;
      pdata[i] = o_data[i];
      plast[i] = o_last[i];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_run(input logic [DW-1:0] s, input int l, input int n);
    r_seed = s;
    r_len = l;
    r_num = n;
    for (int i = 0; i < 2; i++) begin
      hs_idx[i] = 0;
      pkts[i] = 0;
      done_cnt[i] = 0;
      gap_open[i] = 0;
    end
    n_cap = 0;
    seed = s;
    pkt_len = 8'(l);
    pkt_num = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: tready=1, mode 1: fixed stall pattern, mode 2: random tready and input churn
  task automatic run(input logic [DW-1:0] s, input int l, input int n, input int mode, input bit extra);
    logic [7:0] tr_pat;
    int k;
    tr_pat = 8'b11101001;
    tready = 1'b1;
    begin_run(s, l, n);
    k = 0;
    while (k < 3000 && !(done_cnt[0] > 0 && done_cnt[1] > 0)) begin
      case (mode)
        0: tready = 1'b1;
        1: tready = (k < 8) ? tr_pat[k] : 1'b1;
        default: begin
          tready = 1'($urandom_range(0, 1));
          seed = DW'($urandom);
          pkt_len = 8'($urandom);
          pkt_num = 8'($urandom);
        end
      endcase
      start = (extra && k == 2);
      tick();
      k++;
    end
    start = 1'b0;
    chk("run_completed", done_cnt[0] > 0 && done_cnt[1] > 0, 1);
    repeat (4) begin
      tready = 1'($urandom_range(0, 1));
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      chk("single_done", done_cnt[i], 1);
      chk("idle_busy", o_busy[i], 0);
    end
    $display("run seed=%02h len=%0d num=%0d mode=%0d beats=%0d/%0d", s, l, n, mode, hs_idx[0], hs_idx[1]);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", o_valid[i], 0);
      chk("rst_last", o_last[i], 0);
      chk("rst_data", o_data[i], 0);
      chk("rst_busy", o_busy[i], 0);
      chk("rst_done", o_done[i], 0);
      chk("rst_beats", o_beats[i], 0);
    end
    rst = 1'b0;
    tick();

`ifdef AXIS_SRC_LFSR_EN
    run(8'h01, 3, 1, 0, 0);
    chk("lfsr_b0", cap_d[0], 8'h01);
    chk("lfsr_b1", cap_d[1], 8'hB8);
    chk("lfsr_b2", cap_d[2], 8'h5C);
`else
    run(8'h10, 4, 1, 0, 0);
    chk("basic_b0", cap_d[0], 8'h10);
    chk("basic_b1", cap_d[1], 8'h11);
    chk("basic_b2", cap_d[2], 8'h12);
    chk("basic_b3", cap_d[3], 8'h13);
    chk("basic_last2", cap_l[2], 0);
    chk("basic_last3", cap_l[3], 1);
    chk("basic_tx_beats", o_beats[0], 4);
    chk("basic_done_lat", done_cyc, last_hs_cyc + 1);

    run(8'hFE, 3, 2, 0, 0);
    chk("b2b_b2", cap_d[2], 8'h00);
    chk("b2b_b3", cap_d[3], 8'h01);
    chk("b2b_b5", cap_d[5], 8'h03);
    chk("b2b_last2", cap_l[2], 1);
    chk("b2b_last3", cap_l[3], 0);
    chk("b2b_last5", cap_l[5], 1);
    chk("b2b_span", last_hs_cyc - first_hs_cyc, 5);
`endif

    run(8'h20, 5, 1, 1, 0);
    chk("bp_handshakes", n_cap, 5);

    run(8'h30, 2, 3, 0, 1);

    // Zero length or zero count must be ignored entirely.
    for (int z = 0; z < 2; z++) begin
      pkt_len = (z == 0) ? 8'd0 : 8'd3;
      pkt_num = (z == 0) ? 8'd3 : 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) begin
        tick();
        for (int i = 0; i < 2; i++) begin
          chk("zero_valid", o_valid[i], 0);
          chk("zero_busy", o_busy[i], 0);
          chk("zero_done", o_done[i], 0);
        end
      end
    end

    // Asynchronous reset in the middle of a packet.
    tready = 1'b1;
    begin_run(8'h40, 6, 2);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_valid", o_valid[i], 0);
      chk("arst_busy", o_busy[i], 0);
      chk("arst_beats", o_beats[i], 0);
      tot[i] = 0;
      stall[i] = 0;
      gap_open[i] = 0;
      hs_idx[i] = r_len * r_num;
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    run(8'h77, 4, 2, 2, 0);
    chk("post_rst_first", cap_d[0], 8'h77);
    chk("post_rst_beats", o_beats[0], 8);

    run(8'h00, 255, 2, 0, 0);
    run(8'hA5, 1, 255, 0, 0);

    repeat (6) begin
      int l, n;
      l = $urandom_range(1, 6);
      n = $urandom_range(1, 4);
      run(DW'($urandom), l, n, 2, (l * n >= 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi4_str_src.md
Name: axi4_str_src

Overview:
- AXI4-Stream master traffic source, single clock domain. It is the transmitter that drives the slave side of the stream FIFO.
- On a start pulse it emits pkt_num packets of pkt_len beats each. Data follows a deterministic pattern, tlast marks the end of each packet, and an optional idle gap separates packets.
- Used in bring-up and as stimulus for stream FIFOs and bridges.

Parameters:
- DATA_WDTH, 8, tdata width; legal values 8/16/32/64, any other value triggers $fatal at elaboration.
- LEN_WDTH, 8, width of pkt_len and of the beat-in-packet counter.
- NUM_WDTH, 8, width of pkt_num and of the packet counter.
- GAP_CYC, 0, idle cycles (tvalid=0) between packets; 0 means back-to-back.

Ports:
- clk  in  1  Single clock; all logic on rising edge.
- rst  in  1  Reset, asynchronous assert, active-high.
- start  in  1  Run request; sampled only in IDLE.
- pkt_len  in  LEN_WDTH  Beats per packet; latched on accepted start.
- pkt_num  in  NUM_WDTH  Packets per run; latched on accepted start.
- seed  in  DATA_WDTH  First data word of the run; latched on accepted start.
- m_axis_tready  in  1  Downstream ready.
- m_axis_tdata  out  DATA_WDTH  Stream data.
- m_axis_tvalid  out  1  Stream valid.
- m_axis_tlast  out  1  Last beat of packet.
- busy  out  1  Run in progress.
- done  out  1  One-cycle pulse at end of run.
- tx_beats  out  32  Total handshakes since reset; wraps modulo 2^32.

Behaviour:
- All outputs are registered. Reset values: tvalid=0, tlast=0, tdata=0, busy=0, done=0, tx_beats=0.
- Reset asserted mid-run: outputs clear immediately and asynchronously, the FSM returns to IDLE, and the partial packet is abandoned.
- FSM states: IDLE, SEND, GAP, FIN.
- IDLE:
  - start=1 with pkt_len!=0 and pkt_num!=0: latch inputs, go to SEND. busy=1 from the next cycle.
  - start with pkt_len=0 or pkt_num=0: ignored; no busy, no done.
- SEND:
  - tvalid=1. The first beat appears the cycle after start is accepted, with tdata=seed.
  - Handshake = tvalid & tready. On each handshake, tdata advances to the next pattern value and the beat counter increments.
  - Pattern: increment by 1 modulo 2^DATA_WDTH, continuous across packet boundaries (not restarted per packet).
  - tlast=1 exactly on beat index pkt_len-1; pkt_len=1 gives tlast on every beat.
- AXI rules:
  - tvalid never depends combinationally on tready.
  - While tvalid=1 and tready=0, tdata and tlast hold stable and tvalid stays high.
  - tvalid never drops before its handshake.
- Last-beat handshake of a packet that is not the last packet:
  - GAP_CYC>0: enter GAP with tvalid=0 for exactly GAP_CYC cycles, then return to SEND.
  - GAP_CYC=0: the next packet's first beat is presented in the following cycle with tvalid held continuously at 1.
- Last-beat handshake of the last packet:
  - Go to FIN with tvalid=0 and tlast=0.
  - In FIN: done=1 and busy=0 for one cycle, then IDLE.
  - A new start is accepted in the cycle after FIN.
- start asserted while busy: ignored.
- pkt_len, pkt_num and seed changes during a run: ignored.
- Counters:
  - Beat counter LEN_WDTH bits; packet counter NUM_WDTH bits.
  - pkt_len = 2^LEN_WDTH-1 and pkt_num = 2^NUM_WDTH-1 must work without overflow.
- tx_beats increments on every handshake in every state.
- Throughput: 1 beat per cycle with tready held at 1 and GAP_CYC=0.

Optional Feature:
- Macro: AXIS_SRC_LFSR_EN.
- Defined: pattern is a Galois right-shift LFSR, next = (d>>1) ^ (d[0] ? TAPS : 0).
  - TAPS: 8'hB8, 16'hB400, 32'h80200003, 64'hD800000000000000.
  - seed=0 is replaced by all-ones when latched, since the LFSR cannot leave the zero state.
  - LFSR state advances only on handshake.
- Undefined: increment pattern, no LFSR logic synthesized.

Test Plan:
- Basic run: DATA_WDTH=8, seed=8'h10, pkt_len=4, pkt_num=1, tready=1.
  - Required: tdata 10,11,12,13 on consecutive cycles; tlast only on 13; done pulse one cycle after the last beat; tx_beats=4.
- Back-to-back, rollover: seed=8'hFE, pkt_len=3, pkt_num=2, GAP_CYC=0.
  - Required: tdata FE,FF,00 | 01,02,03 with tvalid continuously 1; tlast on 00 and 03.
- Backpressure: pkt_len=5; tready pattern 1,0,0,1,0,1,1,1.
  - Required: tdata/tlast stable through every stall; tvalid never drops; 5 handshakes in order.
- Gap and ignored start: GAP_CYC=3, pkt_len=2, pkt_num=3, start pulsed again while busy.
  - Required: exactly 3 tvalid=0 cycles between packets; second start has no effect; single done.
- Zero length and mid-run reset:
  - pkt_len=0 with start -> no activity.
  - rst asserted mid-packet -> tvalid=0 immediately, busy=0; after release a new start gives a fresh run from the new seed.
- LFSR (AXIS_SRC_LFSR_EN, DATA_WDTH=8): seed=8'h01, pkt_len=3.
  - Required: tdata 01,B8,5C.
